// File: rtl/serdesphy_rx_pkg.sv
// serdesphy_rx_pkg
// Shared definitions for the SerDes PHY RX link trainer:
//   - TIMER_W        : width of the phase timer and the PRBS error counter
//   - train_state_e  : trainer FSM state encoding
//   - FAIL_*         : fail_code values reported to the CSR block
//   - rx_ctl()       : RX control word {rx_en, rx_align_rst, rx_prbs_chk_en,
//                      rx_fifo_en, rx_data_sel} driven in each state
package serdesphy_rx_pkg;

  localparam int TIMER_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ALIGN_RST  = 3'd1,
    ST_WAIT_ALIGN = 3'd2,
    ST_PRBS_CHK   = 3'd3,
    ST_DATA_EN    = 3'd4,
    ST_LINKED     = 3'd5,
    ST_FAIL       = 3'd6
  } train_state_e;

  localparam logic [1:0] FAIL_NONE   = 2'b00;
  localparam logic [1:0] FAIL_ALIGN  = 2'b01;
  localparam logic [1:0] FAIL_PRBS   = 2'b10;
  localparam logic [1:0] FAIL_RX_ERR = 2'b11;

  // Control word order: {rx_en, rx_align_rst, rx_prbs_chk_en, rx_fifo_en, rx_data_sel}
  function automatic logic [4:0] rx_ctl(input train_state_e s);
    logic [4:0] c;
    c = 5'b00000;
    case (s)
      ST_ALIGN_RST:          c = 5'b11000;
      ST_WAIT_ALIGN:         c = 5'b10000;
      ST_PRBS_CHK:           c = 5'b10101;
      ST_DATA_EN, ST_LINKED: c = 5'b10010;
      default:               c = 5'b00000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/serdesphy_rx_train_timer.sv
// serdesphy_rx_train_timer
// Up-counter with synchronous clear and count enable, plus an equality
// compare against a terminal value. Used both as the trainer's phase timer
// and (with term tied to all-ones and enable gated by at_term) as a
// saturating error counter.
// Ports:
//   clk_24m  : clock, rising edge
//   rst_24m  : asynchronous active-high reset, clears count
//   clr      : synchronous clear (wins over en)
//   en       : increment enable
//   term     : terminal compare value
//   count    : current count
//   at_term  : count == term (combinational)
import serdesphy_rx_pkg::*;

module serdesphy_rx_train_timer #(
  parameter int W = TIMER_W
) (
  input  logic         clk_24m,
  input  logic         rst_24m,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         at_term
);

  always_ff @(posedge clk_24m or posedge rst_24m) begin
    if (rst_24m) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign at_term = (count == term);

endmodule

// File: rtl/serdesphy_rx_link_trainer.sv
// serdesphy_rx_link_trainer
// Link-training sequencer for the SerDes RX path: pulses alignment reset,
// waits for alignment, runs a PRBS check window, then switches the RX path
// into FIFO data mode. Failed attempts are retried up to MAX_RETRIES times.
// Optional build macro: SERDESPHY_RX_TRAIN_MONITOR_EN -- when defined, loss
// of alignment or an RX error while LINKED counts as a failed attempt.
// Ports:
//   clk_24m, rst_24m       : clock and asynchronous active-high reset
//   train_start            : level, starts training from IDLE or FAIL
//   train_abort            : level, forces IDLE from any state (top priority)
//   rx_aligned, prbs_err, rx_error : status from the RX top
//   rx_en, rx_align_rst, rx_prbs_chk_en, rx_fifo_en, rx_data_sel : RX controls
//   train_busy/done/fail   : status for the CSR block
//   fail_code              : last failure cause (00 none, 01 align, 10 PRBS, 11 RX error)
//   retry_cnt              : retries used in the current training
//   train_state            : current FSM state (debug visibility)
// All outputs are registered and reflect the state entered at the last edge.
import serdesphy_rx_pkg::*;

module serdesphy_rx_link_trainer #(
  parameter int ALIGN_RST_CYCLES = 4,
  parameter int ALIGN_TIMEOUT    = 4096,
  parameter int PRBS_WINDOW      = 1024,
  parameter int ERR_THRESH       = 0,
  parameter int MAX_RETRIES      = 3
) (
  input  logic       clk_24m,
  input  logic       rst_24m,
  input  logic       train_start,
  input  logic       train_abort,
  input  logic       rx_aligned,
  input  logic       prbs_err,
  input  logic       rx_error,
  output logic       rx_en,
  output logic       rx_align_rst,
  output logic       rx_prbs_chk_en,
  output logic       rx_fifo_en,
  output logic       rx_data_sel,
  output logic       train_busy,
  output logic       train_done,
  output logic       train_fail,
  output logic [1:0] fail_code,
  output logic [3:0] retry_cnt,
  output logic [2:0] train_state
);

  train_state_e        state_q, state_d;
  logic [1:0]          code_d;
  logic [3:0]          retry_d;
  logic                attempt_fail;
  logic [1:0]          fail_cause;

  logic [TIMER_W-1:0]  tmr_term;
  logic [TIMER_W-1:0]  tmr_count;
  logic                tmr_at_term;
  logic                tmr_en;
  logic [TIMER_W-1:0]  err_count;
  logic                err_sat;
  logic                err_en;
  logic                state_change;
  logic [TIMER_W:0]    err_sum;
  logic                err_breach;

  // Both counters restart whenever a new state is entered.
  assign state_change = (state_d != state_q);

  always_comb begin
    tmr_term = '1;
    case (state_q)
      ST_ALIGN_RST:  tmr_term = TIMER_W'(ALIGN_RST_CYCLES - 1);
      ST_WAIT_ALIGN: tmr_term = TIMER_W'(ALIGN_TIMEOUT - 1);
      ST_PRBS_CHK:   tmr_term = TIMER_W'(PRBS_WINDOW - 1);
      default:       tmr_term = '1;
    endcase
  end

  assign tmr_en = (state_q == ST_ALIGN_RST) || (state_q == ST_WAIT_ALIGN) ||
                  (state_q == ST_PRBS_CHK);

  serdesphy_rx_train_timer #(.W(TIMER_W)) u_phase_timer (
    .clk_24m (clk_24m),
    .rst_24m (rst_24m),
    .clr     (state_change),
    .en      (tmr_en),
    .term    (tmr_term),
    .count   (tmr_count),
    .at_term (tmr_at_term)
  );

  // Error counter saturates at all-ones: the terminal compare blocks the increment.
  assign err_en = (state_q == ST_PRBS_CHK) && prbs_err && !err_sat;

  serdesphy_rx_train_timer #(.W(TIMER_W)) u_err_counter (
    .clk_24m (clk_24m),
    .rst_24m (rst_24m),
    .clr     (state_change),
    .en      (err_en),
    .term    ({TIMER_W{1'b1}}),
    .count   (err_count),
    .at_term (err_sat)
  );

  // Threshold is judged on the count including this cycle's strobe, so the
  // attempt fails at the same edge the offending error is sampled -- this is
  // also what makes an error on the last window cycle beat the window end.
  assign err_sum    = {1'b0, err_count} + {{TIMER_W{1'b0}}, (prbs_err && !err_sat)};
  assign err_breach = (err_sum > (TIMER_W+1)'(ERR_THRESH));

  always_comb begin
    state_d      = state_q;
    code_d       = fail_code;
    retry_d      = retry_cnt;
    attempt_fail = 1'b0;
    fail_cause   = FAIL_NONE;

    if (train_abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_FAIL: begin
          if (train_start) begin
            state_d = ST_ALIGN_RST;
            retry_d = 4'd0;
            code_d  = FAIL_NONE;
          end
        end
        ST_ALIGN_RST: begin
          if (tmr_at_term) state_d = ST_WAIT_ALIGN;
        end
        ST_WAIT_ALIGN: begin
          if (rx_error) begin
            attempt_fail = 1'b1;
            fail_cause   = FAIL_RX_ERR;
          end else if (rx_aligned) begin
            state_d = ST_PRBS_CHK;
          end else if (tmr_at_term) begin
            attempt_fail = 1'b1;
            fail_cause   = FAIL_ALIGN;
          end
        end
        ST_PRBS_CHK: begin
          if (rx_error) begin
            attempt_fail = 1'b1;
            fail_cause   = FAIL_RX_ERR;
          end else if (err_breach) begin
            attempt_fail = 1'b1;
            fail_cause   = FAIL_PRBS;
          end else if (!rx_aligned) begin
            attempt_fail = 1'b1;
            fail_cause   = FAIL_ALIGN;
          end else if (tmr_at_term) begin
            state_d = ST_DATA_EN;
          end
        end
        ST_DATA_EN: begin
          state_d = ST_LINKED;
        end
        ST_LINKED: begin
`ifdef SERDESPHY_RX_TRAIN_MONITOR_EN
          if (rx_error) begin
            attempt_fail = 1'b1;
            fail_cause   = FAIL_RX_ERR;
          end else if (!rx_aligned) begin
            attempt_fail = 1'b1;
            fail_cause   = FAIL_ALIGN;
          end
`else
          state_d = ST_LINKED;
`endif
        end
        default: state_d = ST_IDLE;
      endcase

      if (attempt_fail) begin
        code_d = fail_cause;
        if (retry_cnt < 4'(MAX_RETRIES)) begin
          retry_d = retry_cnt + 4'd1;
          state_d = ST_ALIGN_RST;
        end else begin
          state_d = ST_FAIL;
        end
      end
    end
  end

  // Outputs are decoded from the next state so they line up with the state
  // register (one cycle after the inputs that caused the transition).
  always_ff @(posedge clk_24m or posedge rst_24m) begin
    if (rst_24m) begin
      state_q        <= ST_IDLE;
      fail_code      <= FAIL_NONE;
      retry_cnt      <= 4'd0;
      rx_en          <= 1'b0;
      rx_align_rst   <= 1'b0;
      rx_prbs_chk_en <= 1'b0;
      rx_fifo_en     <= 1'b0;
      rx_data_sel    <= 1'b0;
      train_busy     <= 1'b0;
      train_done     <= 1'b0;
      train_fail     <= 1'b0;
    end else begin
      state_q   <= state_d;
      fail_code <= code_d;
      retry_cnt <= retry_d;
      {rx_en, rx_align_rst, rx_prbs_chk_en, rx_fifo_en, rx_data_sel} <= rx_ctl(state_d);
      train_busy <= (state_d == ST_ALIGN_RST) || (state_d == ST_WAIT_ALIGN) ||
                    (state_d == ST_PRBS_CHK)  || (state_d == ST_DATA_EN);
      train_done <= (state_d == ST_LINKED);
      train_fail <= (state_d == ST_FAIL);
    end
  end

  assign train_state = state_q;

endmodule

// File: tb/tb_serdesphy_rx_link_trainer.sv
// Testbench for serdesphy_rx_link_trainer. Scenarios are described at the
// level of training phases; a reference model turns each into a per-cycle
// stimulus queue and an expected-output queue, which are then played against
// the DUT cycle by cycle.
import serdesphy_rx_pkg::*;

module tb_serdesphy_rx_link_trainer;

  localparam int A  = 4;   // ALIGN_RST_CYCLES
  localparam int T  = 40;  // ALIGN_TIMEOUT
  localparam int W  = 24;  // PRBS_WINDOW
  localparam int TH = 2;   // ERR_THRESH
  localparam int MR = 3;   // MAX_RETRIES

  // Model phases (bench-local, independent of the RTL encoding)
  localparam int PH_IDLE = 0, PH_ARST = 1, PH_WAIT = 2, PH_PRBS = 3,
                 PH_DATA = 4, PH_LINK = 5, PH_FAIL = 6;

  // ---------------- clock / reset ----------------
  logic clk_24m = 1'b0;
  logic rst_24m = 1'b1;
  always #5 clk_24m = ~clk_24m;

  logic       train_start = 1'b0, train_abort = 1'b0;
  logic       rx_aligned = 1'b0, prbs_err = 1'b0, rx_error = 1'b0;
  logic       rx_en, rx_align_rst, rx_prbs_chk_en, rx_fifo_en, rx_data_sel;
  logic       train_busy, train_done, train_fail;
  logic [1:0] fail_code;
  logic [3:0] retry_cnt;
  logic [2:0] train_state;

  serdesphy_rx_link_trainer #(
    .ALIGN_RST_CYCLES (A),
    .ALIGN_TIMEOUT    (T),
    .PRBS_WINDOW      (W),
    .ERR_THRESH       (TH),
    .MAX_RETRIES      (MR)
  ) dut (
    .clk_24m        (clk_24m),
    .rst_24m        (rst_24m),
    .train_start    (train_start),
    .train_abort    (train_abort),
    .rx_aligned     (rx_aligned),
    .prbs_err       (prbs_err),
    .rx_error       (rx_error),
    .rx_en          (rx_en),
    .rx_align_rst   (rx_align_rst),
    .rx_prbs_chk_en (rx_prbs_chk_en),
    .rx_fifo_en     (rx_fifo_en),
    .rx_data_sel    (rx_data_sel),
    .train_busy     (train_busy),
    .train_done     (train_done),
    .train_fail     (train_fail),
    .fail_code      (fail_code),
    .retry_cnt      (retry_cnt),
    .train_state    (train_state)
  );

  logic [13:0] obs;
  assign obs = {rx_en, rx_align_rst, rx_prbs_chk_en, rx_fifo_en, rx_data_sel,
                train_busy, train_done, train_fail, fail_code, retry_cnt};

  // ---------------- scoreboard ----------------
  int          vectors = 0;
  int          miscompares = 0;
  logic [4:0]  in_q[$];   // {start, abort, aligned, prbs_err, rx_error} per edge
  logic [13:0] exp_q[$];  // outputs expected after that edge

  // Model state
  int          m_ph = PH_IDLE;
  logic [1:0]  m_code = 2'b00;
  logic [3:0]  m_retry = 4'd0;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [4:0] mk(input logic s, input logic a, input logic al,
                                    input logic pe, input logic re);
    return {s, a, al, pe, re};
  endfunction

  function automatic logic [13:0] outs(input int ph);
    logic [4:0] ctl;
    logic busy, done, fl;
    ctl  = 5'b00000;
    case (ph)
      PH_ARST:          ctl = 5'b11000;
      PH_WAIT:          ctl = 5'b10000;
      PH_PRBS:          ctl = 5'b10101;
      PH_DATA, PH_LINK: ctl = 5'b10010;
      default:          ctl = 5'b00000;
    endcase
    busy = (ph == PH_ARST) || (ph == PH_WAIT) || (ph == PH_PRBS) || (ph == PH_DATA);
    done = (ph == PH_LINK);
    fl   = (ph == PH_FAIL);
    return {ctl, busy, done, fl, m_code, m_retry};
  endfunction

  task automatic push(input logic [4:0] i, input int ph);
    m_ph = ph;
    in_q.push_back(i);
    exp_q.push_back(outs(ph));
  endtask

  task automatic m_start();
    m_retry = 4'd0;
    m_code  = 2'b00;
    push(mk(1'b1, 1'b0, rb(), rb(), rb()), PH_ARST);
  endtask

  // Remaining alignment-reset cycles after entry, ending in WAIT.
  task automatic m_align_rst();
    for (int i = 0; i < A - 1; i++) push(mk(rb(), 1'b0, rb(), rb(), rb()), PH_ARST);
    push(mk(rb(), 1'b0, rb(), rb(), rb()), PH_WAIT);
  endtask

  task automatic m_fail(input logic [1:0] code, input logic [4:0] i);
    m_code = code;
    if (m_retry < 4'(MR)) begin
      m_retry = m_retry + 4'd1;
      push(i, PH_ARST);
      m_align_rst();
    end else begin
      push(i, PH_FAIL);
    end
  endtask

  // kind 0: aligned after d cycles, 1: timeout, 2: rx_error after d cycles
  task automatic m_wait(input int kind, input int d);
    if (kind == 1) begin
      for (int i = 0; i < T - 1; i++) push(mk(rb(), 1'b0, 1'b0, rb(), 1'b0), PH_WAIT);
      m_fail(2'b01, mk(rb(), 1'b0, 1'b0, rb(), 1'b0));
    end else begin
      for (int i = 0; i < d; i++) push(mk(rb(), 1'b0, 1'b0, rb(), 1'b0), PH_WAIT);
      if (kind == 0) push(mk(rb(), 1'b0, 1'b1, rb(), 1'b0), PH_PRBS);
      else           m_fail(2'b11, mk(rb(), 1'b0, rb(), rb(), 1'b1));
    end
  endtask

  // kind 0: clean window, 1: threshold breach at p, 2: align drop at p,
  // 3: rx_error together with breach at p, 4: abort at p
  task automatic m_prbs(input int kind, input int p);
    logic e [0:W-1];
    int   pos;
    for (int i = 0; i < W; i++) e[i] = 1'b0;
    if (kind == 0) begin
      for (int j = 0; j < $urandom_range(0, TH); j++) e[$urandom_range(0, W - 1)] = 1'b1;
      for (int i = 0; i < W - 1; i++) push(mk(rb(), 1'b0, 1'b1, e[i], 1'b0), PH_PRBS);
      push(mk(rb(), 1'b0, 1'b1, e[W-1], 1'b0), PH_DATA);
      push(mk(rb(), 1'b0, rb(), rb(), rb()), PH_LINK);
    end else begin
      if (kind == 1 || kind == 3) begin
        for (int j = 0; j < TH; j++) begin
          pos = $urandom_range(0, p - 1);
          while (e[pos]) pos = $urandom_range(0, p - 1);
          e[pos] = 1'b1;
        end
      end
      for (int i = 0; i < p; i++) push(mk(rb(), 1'b0, 1'b1, e[i], 1'b0), PH_PRBS);
      case (kind)
        1:       m_fail(2'b10, mk(rb(), 1'b0, 1'b1, 1'b1, 1'b0));
        2:       m_fail(2'b01, mk(rb(), 1'b0, 1'b0, 1'b0, 1'b0));
        3:       m_fail(2'b11, mk(rb(), 1'b0, rb(), 1'b1, 1'b1));
        default: push(mk(rb(), 1'b1, rb(), rb(), rb()), PH_IDLE);
      endcase
    end
  endtask

  task automatic m_linked(input int n);
    for (int i = 0; i < n; i++) push(mk(rb(), 1'b0, 1'b1, rb(), 1'b0), PH_LINK);
  endtask

  task automatic m_hold(input int ph, input int n);
    for (int i = 0; i < n; i++) push(mk(1'b0, 1'b0, rb(), rb(), rb()), ph);
  endtask

  task automatic m_abort();
    push(mk(rb(), 1'b1, rb(), rb(), rb()), PH_IDLE);
  endtask

  // Play queued stimulus; one comparison per edge.
  task automatic run_q(input string name);
    logic [4:0]  i;
    logic [13:0] e;
    while (in_q.size() > 0) begin
      i = in_q.pop_front();
      {train_start, train_abort, rx_aligned, prbs_err, rx_error} = i;
      @(posedge clk_24m);
      #1;
      e = exp_q.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL %s vec %0d: outputs %b, expected %b (in %b)", name, vectors, obs, e, i);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    vectors++;
    if (obs !== 14'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: outputs %b, expected %b", obs, 14'd0);
    end
    vectors++;
    if (train_state !== ST_IDLE) begin
      miscompares++;
      $display("FAIL reset_state: state %0d, expected %0d", train_state, ST_IDLE);
    end
    @(posedge clk_24m);
    #1;
    rst_24m = 1'b0;
    m_hold(PH_IDLE, 3);
    run_q("idle_hold");
  endtask

  task automatic test_clean_link();
    m_start();
    m_align_rst();
    m_wait(0, 0);
    m_prbs(0, 0);
    m_linked(4);
    m_abort();
    m_start();
    m_align_rst();
    m_wait(0, $urandom_range(1, 8));
    m_prbs(0, 0);
    m_linked(3);
    run_q("clean_link");
  endtask

  task automatic test_align_timeout();
    if (m_ph != PH_IDLE && m_ph != PH_FAIL) m_abort();
    m_start();
    m_align_rst();
    for (int k = 0; k <= MR; k++) m_wait(1, 0);
    m_hold(PH_FAIL, 3);
    run_q("align_timeout");
  endtask

  task automatic test_prbs_threshold();
    if (m_ph != PH_IDLE && m_ph != PH_FAIL) m_abort();
    m_start();
    m_align_rst();
    m_wait(0, $urandom_range(0, 5));
    m_prbs(1, $urandom_range(TH, W - 2));
    m_wait(0, $urandom_range(0, 5));
    m_prbs(0, 0);
    m_linked(3);
    run_q("prbs_threshold");
  endtask

  task automatic test_simultaneous();
    if (m_ph != PH_IDLE && m_ph != PH_FAIL) m_abort();
    m_start();
    m_align_rst();
    m_wait(0, 2);
    m_prbs(3, $urandom_range(TH, W - 1));   // rx_error + breach -> 11
    m_wait(0, 1);
    m_prbs(1, W - 1);                       // breach on last window cycle -> 10
    m_wait(2, $urandom_range(0, 6));        // rx_error while waiting -> 11
    m_wait(0, 0);
    m_prbs(2, $urandom_range(0, W - 1));    // alignment lost, out of retries -> FAIL
    m_hold(PH_FAIL, 2);
    run_q("simultaneous");
  endtask

  task automatic test_abort();
    if (m_ph != PH_IDLE && m_ph != PH_FAIL) m_abort();
    m_start();
    m_align_rst();
    m_wait(0, 3);
    m_prbs(4, $urandom_range(0, W - 1));
    m_hold(PH_IDLE, 3);
    m_start();
    m_align_rst();
    for (int i = 0; i < 2; i++) push(mk(rb(), 1'b0, 1'b0, rb(), 1'b0), PH_WAIT);
    m_abort();
    run_q("abort");
  endtask

  task automatic test_reset_in_linked();
    if (m_ph != PH_IDLE && m_ph != PH_FAIL) m_abort();
    m_start();
    m_align_rst();
    m_wait(0, 0);
    m_prbs(0, 0);
    m_linked(2);
    run_q("pre_reset");
    #2;
    rst_24m = 1'b1;
    #1;
    vectors++;
    if (obs !== 14'd0) begin
      miscompares++;
      $display("FAIL async_reset: outputs %b, expected %b", obs, 14'd0);
    end
    @(posedge clk_24m);
    #1;
    rst_24m = 1'b0;
    m_ph = PH_IDLE;
    m_code = 2'b00;
    m_retry = 4'd0;
    m_hold(PH_IDLE, 2);
    run_q("post_reset");
  endtask

  task automatic test_monitor();
    if (m_ph != PH_IDLE && m_ph != PH_FAIL) m_abort();
    m_start();
    m_align_rst();
    m_wait(0, 1);
    m_prbs(0, 0);
    m_linked(2);
`ifdef SERDESPHY_RX_TRAIN_MONITOR_EN
    m_fail(2'b01, mk(rb(), 1'b0, 1'b0, rb(), 1'b0));
    m_wait(0, 0);
    m_prbs(0, 0);
    m_linked(2);
`else
    push(mk(rb(), 1'b0, 1'b0, rb(), 1'b0), PH_LINK);
    push(mk(rb(), 1'b0, 1'b1, rb(), 1'b1), PH_LINK);
    for (int i = 0; i < 4; i++) push(mk(rb(), 1'b0, rb(), rb(), rb()), PH_LINK);
`endif
    run_q("monitor");
  endtask

  task automatic test_random();
    int wk, pk, done;
    repeat (8) begin
      if (m_ph != PH_IDLE && m_ph != PH_FAIL) m_abort();
      m_start();
      m_align_rst();
      done = 0;
      while (done == 0) begin
        wk = $urandom_range(0, 3);
        if (wk <= 1)      m_wait(0, $urandom_range(0, 6));
        else if (wk == 2) m_wait(1, 0);
        else              m_wait(2, $urandom_range(0, 6));
        if (m_ph == PH_PRBS) begin
          pk = $urandom_range(0, 5);
          case (pk)
            0, 1: m_prbs(0, 0);
            2:    m_prbs(1, $urandom_range(TH, W - 1));
            3:    m_prbs(2, $urandom_range(0, W - 1));
            4:    m_prbs(3, $urandom_range(TH, W - 1));
            default: m_prbs(4, $urandom_range(0, W - 1));
          endcase
        end
        if (m_ph == PH_LINK || m_ph == PH_IDLE || m_ph == PH_FAIL) done = 1;
      end
      if (m_ph == PH_LINK) m_linked(3);
      run_q("random");
    end
  endtask

  initial begin
    repeat (2) @(posedge clk_24m);
    #1;
    test_reset();
    test_clean_link();
    test_align_timeout();
    test_prbs_threshold();
    test_simultaneous();
    test_abort();
    test_reset_in_linked();
    test_monitor();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
